// File: rtl/nt_response_compactor_if.sv
// Bus bundle between a response source/session controller and the compactor.
interface nt_response_compactor_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] n_patterns;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_in;
    logic [WIDTH-1:0] golden;
    logic             busy;
    logic             done;
    logic             match;
    logic [WIDTH-1:0] signature;
    logic [CNT_W-1:0] count;

    modport master (
        output start, n_patterns, resp_valid, resp_in, golden,
        input  busy, done, match, signature, count
    );

    modport slave (
        input  start, n_patterns, resp_valid, resp_in, golden,
        output busy, done, match, signature, count
    );
endinterface

// File: rtl/nt_response_compactor.sv
// MISR response compactor: folds a programmed number of valid response words
// into a signature and reports a registered match against a golden value.
module nt_response_compactor #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY = WIDTH'(16'h100B),
    parameter logic [WIDTH-1:0] SEED = WIDTH'(16'hFFFF),
    parameter int              CNT_W = 16
) (
    input logic                   I1470,
    input logic                   I1477,
    nt_response_compactor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] sig_q, sig_n, sig_step;
    logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
    logic [CNT_W-1:0] target_q, target_n;
    logic             match_q, match_n;
    logic             busy_q, done_q;

    assign sig_step = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ bus.resp_in;
    assign cnt_inc  = cnt_q + CNT_W'(1);

    always_ff @(posedge I1470) begin
        if (!I1477) begin
            state_q  <= IDLE;
            sig_q    <= SEED;
            cnt_q    <= '0;
            target_q <= '0;
            match_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            sig_q    <= sig_n;
            cnt_q    <= cnt_n;
            target_q <= target_n;
            match_q  <= match_n;
            busy_q   <= (state_n == RUN);
            done_q   <= (state_n == DONE);
        end
    end

    always_comb begin
        state_n  = state_q;
        sig_n    = sig_q;
        cnt_n    = cnt_q;
        target_n = target_q;
        match_n  = match_q;
        case (state_q)
            // DONE restarts exactly like IDLE, without an intermediate IDLE cycle
            IDLE, DONE: begin
                if (bus.start) begin
                    target_n = bus.n_patterns;
                    sig_n    = SEED;
                    cnt_n    = '0;
                    if (bus.n_patterns != '0) begin
                        state_n = RUN;
                        match_n = 1'b0;
                    end else begin
                        state_n = DONE;
                        match_n = (SEED == bus.golden);
                    end
                end
            end
            RUN: begin
                if (bus.resp_valid) begin
                    sig_n = sig_step;
                    cnt_n = cnt_inc;
                    if (cnt_inc == target_q) begin
                        state_n = DONE;
                        match_n = (sig_step == bus.golden);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                match_n = 1'b0;
            end
        endcase
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.match     = match_q;
    assign bus.signature = sig_q;
    assign bus.count     = cnt_q;
endmodule

// File: tb/tb_nt_response_compactor.sv
// Scoreboarded bench for nt_response_compactor: a 4-bit build and a default
// 16-bit build share clock and reset.
module tb_nt_response_compactor;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nt_response_compactor_if #(.WIDTH(4),  .CNT_W(16)) b4 ();
    nt_response_compactor_if #(.WIDTH(16), .CNT_W(16)) b16 ();

    nt_response_compactor #(.WIDTH(4), .POLY(4'h3), .SEED(4'h0), .CNT_W(16)) dut4 (
        .I1470(clk), .I1477(rst_n), .bus(b4)
    );
    nt_response_compactor dut16 (
        .I1470(clk), .I1477(rst_n), .bus(b16)
    );

    typedef struct {
        logic [15:0] sig;
        logic        match;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb4[$];
    exp_t sb16[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] w,
                                         input logic [15:0] poly, input int unsigned wd);
        logic [15:0] mask;
        mask = (wd >= 16) ? 16'hFFFF : ((16'h1 << wd) - 16'h1);
        return ((s << 1) ^ (s[wd-1] ? poly : 16'h0) ^ w) & mask;
    endfunction

    // {busy, done, match, count, signature}
    function automatic logic [34:0] snap16();
        return {b16.busy, b16.done, b16.match, b16.count, b16.signature};
    endfunction

    function automatic logic [22:0] snap4();
        return {b4.busy, b4.done, b4.match, b4.count, b4.signature};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sb_pop4(input string tag);
        exp_t e;
        for (int i = 0; i < 20 && !b4.done; i++) tick();
        checks++;
        if (!b4.done) begin
            errors++;
            $display("FAIL %s: done timeout, done=%b required 1", tag, b4.done);
        end else if (sb4.size() == 0) begin
            errors++;
            $display("FAIL %s: done=1 with empty scoreboard, required pending entry", tag);
        end else begin
            e = sb4.pop_front();
            if ({b4.busy, b4.match, b4.count, b4.signature} !== {1'b0, e.match, e.cnt, e.sig[3:0]}) begin
                errors++;
                $display("FAIL %s: busy/match/count/sig=%b/%b/%0d/%h required 0/%b/%0d/%h",
                         tag, b4.busy, b4.match, b4.count, b4.signature, e.match, e.cnt, e.sig[3:0]);
            end
        end
    endtask

    task automatic sb_pop16(input string tag);
        exp_t e;
        for (int i = 0; i < 20 && !b16.done; i++) tick();
        checks++;
        if (!b16.done) begin
            errors++;
            $display("FAIL %s: done timeout, done=%b required 1", tag, b16.done);
        end else if (sb16.size() == 0) begin
            errors++;
            $display("FAIL %s: done=1 with empty scoreboard, required pending entry", tag);
        end else begin
            e = sb16.pop_front();
            if ({b16.busy, b16.match, b16.count, b16.signature} !== {1'b0, e.match, e.cnt, e.sig}) begin
                errors++;
                $display("FAIL %s: busy/match/count/sig=%b/%b/%0d/%h required 0/%b/%0d/%h",
                         tag, b16.busy, b16.match, b16.count, b16.signature, e.match, e.cnt, e.sig);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (snap4() !== {3'b000, 16'd0, 4'h0}) begin
            errors++;
            $display("FAIL reset4: state=%h required %h", snap4(), {3'b000, 16'd0, 4'h0});
        end
        checks++;
        if (snap16() !== {3'b000, 16'd0, 16'hFFFF}) begin
            errors++;
            $display("FAIL reset16: state=%h required %h", snap16(), {3'b000, 16'd0, 16'hFFFF});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_w4_basic();
        logic [15:0] s1, s2;
        s1 = misr(16'h0, 16'h1, 16'h3, 4);
        s2 = misr(s1, 16'h2, 16'h3, 4);
        b4.start = 1'b1; b4.n_patterns = 16'd2; b4.golden = 4'h0; b4.resp_valid = 1'b0;
        sb4.push_back('{sig: s2, match: (s2 == 16'h0), cnt: 16'd2});
        tick();
        b4.start = 1'b0;
        checks++;
        if (snap4() !== {3'b100, 16'd0, 4'h0}) begin
            errors++;
            $display("FAIL w4_start: state=%h required %h", snap4(), {3'b100, 16'd0, 4'h0});
        end
        b4.resp_valid = 1'b1; b4.resp_in = 4'h1;
        tick();
        checks++;
        if ({b4.count, b4.signature} !== {16'd1, s1[3:0]}) begin
            errors++;
            $display("FAIL w4_word1: count/sig=%0d/%h required 1/%h", b4.count, b4.signature, s1[3:0]);
        end
        b4.resp_in = 4'h2;
        tick();
        b4.resp_valid = 1'b0;
        sb_pop4("w4_basic");
    endtask

    task automatic test_w4_feedback();
        logic [15:0] s1, s2;
        s1 = misr(16'h0, 16'h8, 16'h3, 4);
        s2 = misr(s1, 16'h0, 16'h3, 4);
        b4.start = 1'b1; b4.n_patterns = 16'd2; b4.golden = 4'h0;
        sb4.push_back('{sig: s2, match: (s2 == 16'h0), cnt: 16'd2});
        tick();
        b4.start = 1'b0;
        b4.resp_valid = 1'b1; b4.resp_in = 4'h8;
        tick();
        checks++;
        if (b4.signature !== s1[3:0]) begin
            errors++;
            $display("FAIL w4_fb_word1: sig=%h required %h", b4.signature, s1[3:0]);
        end
        b4.resp_in = 4'h0;
        tick();
        b4.resp_valid = 1'b0;
        sb_pop4("w4_feedback");
    endtask

    task automatic test_zero_patterns();
        b16.start = 1'b1; b16.n_patterns = 16'd0; b16.golden = 16'hFFFF; b16.resp_valid = 1'b0;
        sb16.push_back('{sig: 16'hFFFF, match: 1'b1, cnt: 16'd0});
        tick();
        b16.start = 1'b0;
        checks++;
        if ({b16.busy, b16.done} !== 2'b01) begin
            errors++;
            $display("FAIL zero_n: busy/done=%b%b required 01", b16.busy, b16.done);
        end
        sb_pop16("zero_n");
    endtask

    task automatic test_gapped_valid();
        logic [15:0] w [7];
        logic        v [7];
        logic [15:0] c [7];
        logic [15:0] s;
        int          busy_cycles;
        w = '{16'h1234, 16'hDEAD, 16'hBEEF, 16'hABCD, 16'h0F0F, 16'h7777, 16'h8001};
        v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        c = '{16'd1, 16'd1, 16'd1, 16'd2, 16'd3, 16'd3, 16'd4};
        s = 16'hFFFF;
        for (int unsigned i = 0; i < 7; i++) if (v[i]) s = misr(s, w[i], 16'h100B, 16);
        b16.start = 1'b1; b16.n_patterns = 16'd4; b16.golden = s;
        sb16.push_back('{sig: s, match: 1'b1, cnt: 16'd4});
        tick();
        b16.start = 1'b0;
        busy_cycles = b16.busy ? 1 : 0;
        for (int unsigned i = 0; i < 7; i++) begin
            b16.resp_valid = v[i]; b16.resp_in = w[i];
            tick();
            if (b16.busy) busy_cycles++;
            checks++;
            if (b16.count !== c[i]) begin
                errors++;
                $display("FAIL gap_count[%0d]: count=%0d required %0d", i, b16.count, c[i]);
            end
        end
        b16.resp_valid = 1'b0;
        checks++;
        if (busy_cycles != 7) begin
            errors++;
            $display("FAIL gap_busy: busy cycles=%0d required 7", busy_cycles);
        end
        sb_pop16("gapped");
    endtask

    task automatic test_reset_mid();
        logic [15:0] s;
        b16.start = 1'b1; b16.n_patterns = 16'd5; b16.golden = 16'h0000;
        tick();
        b16.start = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            b16.resp_valid = 1'b1; b16.resp_in = 16'h1111 * 16'(i + 1);
            tick();
        end
        rst_n = 1'b0; b16.start = 1'b1;
        tick();
        checks++;
        if (snap16() !== {3'b000, 16'd0, 16'hFFFF}) begin
            errors++;
            $display("FAIL mid_reset: state=%h required %h", snap16(), {3'b000, 16'd0, 16'hFFFF});
        end
        rst_n = 1'b1; b16.resp_valid = 1'b0;
        tick();
        b16.start = 1'b0;
        checks++;
        if (snap16() !== {3'b100, 16'd0, 16'hFFFF}) begin
            errors++;
            $display("FAIL mid_restart: state=%h required %h", snap16(), {3'b100, 16'd0, 16'hFFFF});
        end
        s = 16'hFFFF;
        for (int unsigned i = 0; i < 5; i++) s = misr(s, 16'h0101 << i, 16'h100B, 16);
        sb16.push_back('{sig: s, match: (s == 16'h0000), cnt: 16'd5});
        for (int unsigned i = 0; i < 5; i++) begin
            b16.resp_valid = 1'b1; b16.resp_in = 16'h0101 << i;
            tick();
        end
        b16.resp_valid = 1'b0;
        sb_pop16("reset_mid");
    endtask

    task automatic test_restart_done();
        logic [15:0] s;
        s = misr(16'hFFFF, 16'h5A5A, 16'h100B, 16);
        b16.start = 1'b1; b16.n_patterns = 16'd1; b16.golden = s ^ 16'h0001;
        sb16.push_back('{sig: s, match: 1'b0, cnt: 16'd1});
        tick();
        b16.start = 1'b0;
        checks++;
        if (snap16() !== {3'b100, 16'd0, 16'hFFFF}) begin
            errors++;
            $display("FAIL restart: state=%h required %h", snap16(), {3'b100, 16'd0, 16'hFFFF});
        end
        b16.resp_valid = 1'b1; b16.resp_in = 16'h5A5A;
        tick();
        b16.resp_valid = 1'b0;
        sb_pop16("restart_done");
    endtask

    task automatic test_start_in_run();
        logic [15:0] s;
        logic [15:0] w [3];
        w = '{16'hC001, 16'h0BAD, 16'hF00D};
        s = 16'hFFFF;
        for (int unsigned i = 0; i < 3; i++) s = misr(s, w[i], 16'h100B, 16);
        b16.start = 1'b1; b16.n_patterns = 16'd3; b16.golden = s;
        sb16.push_back('{sig: s, match: 1'b1, cnt: 16'd3});
        tick();
        for (int unsigned i = 0; i < 2; i++) begin
            b16.start = 1'b1; b16.n_patterns = 16'd1;
            b16.resp_valid = 1'b1; b16.resp_in = w[i];
            tick();
            checks++;
            if ({b16.busy, b16.done, b16.count} !== {2'b10, 16'(i + 1)}) begin
                errors++;
                $display("FAIL run_start[%0d]: busy/done/count=%b/%b/%0d required 1/0/%0d",
                         i, b16.busy, b16.done, b16.count, i + 1);
            end
        end
        b16.start = 1'b0; b16.resp_in = w[2];
        tick();
        b16.resp_valid = 1'b0;
        sb_pop16("start_in_run");
    endtask

    initial begin
        rst_n = 1'b0;
        b4.start = 1'b0;  b4.n_patterns = '0;  b4.resp_valid = 1'b0;  b4.resp_in = '0;  b4.golden = '0;
        b16.start = 1'b0; b16.n_patterns = '0; b16.resp_valid = 1'b0; b16.resp_in = '0; b16.golden = '0;
        test_reset();
        test_w4_basic();
        test_w4_feedback();
        test_zero_patterns();
        test_gapped_valid();
        test_reset_mid();
        test_restart_done();
        test_start_in_run();
        checks++;
        if (sb4.size() + sb16.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", sb4.size() + sb16.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
